// File: rtl/image_logic_engine.sv
// Bitwise image ALU with an accumulator: latches a request, computes op(A,B),
// then counts set pixels one row per cycle before presenting the result.
module image_logic_engine #(
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [ImageWidth*ImageHeight-1:0]            imgA,
  input  logic [ImageWidth*ImageHeight-1:0]            imgB,
  input  logic [2:0]                                   op,
  input  logic                                         use_acc,
  input  logic                                         clear_acc,
  input  logic                                         store_acc,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ImageWidth*ImageHeight-1:0]            result,
  output logic [$clog2(ImageWidth*ImageHeight+1)-1:0]  ones,
  output logic                                         busy
);
  localparam int N  = ImageWidth * ImageHeight;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(ImageHeight + 1);

  typedef enum logic [1:0] {IDLE, CALC, COUNT, DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    acc_q, acc_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            store_q, store_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [N-1:0]          calc_res;
  logic [ImageWidth-1:0] row;
  logic [CW-1:0]         row_pop;

  always_comb begin
    calc_res = '0;
    case (op_q)
      3'b000:  calc_res = a_q;
      3'b001:  calc_res = b_q;
      3'b010:  calc_res = ~a_q;
      3'b011:  calc_res = ~b_q;
      3'b100:  calc_res = a_q & b_q;
      3'b101:  calc_res = a_q | b_q;
      3'b110:  calc_res = a_q ^ b_q;
      default: calc_res = ~(a_q ^ b_q);
    endcase
  end

  always_comb begin
    row     = result_q[int'(idx_q)*ImageWidth +: ImageWidth];
    row_pop = '0;
    for (int c = 0; c < ImageWidth; c++) row_pop = row_pop + CW'(row[c]);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    store_d  = store_q;
    acc_d    = acc_q;
    result_d = result_q;
    ones_d   = ones_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = clear_acc ? '0 : (use_acc ? acc_q : imgA);
        b_d     = imgB;
        op_d    = op;
        store_d = store_acc;
        state_d = CALC;
      end
      CALC: begin
        result_d = calc_res;
        ones_d   = '0;
        idx_d    = '0;
        if (store_q) acc_d = calc_res;
        state_d  = COUNT;
      end
      COUNT: begin
        ones_d = ones_q + row_pop;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IW'(ImageHeight - 1)) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      store_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      store_q  <= store_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs show idle values while reset is held, even before the state register clears.
  assign in_ready  = reset || (state_q == IDLE);
  assign out_valid = !reset && (state_q == DONE);
  assign busy      = !reset && (state_q != IDLE);
  assign result    = reset ? '0 : result_q;
  assign ones      = reset ? '0 : ones_q;
endmodule

// File: tb/tb_image_logic_engine.sv
// Directed bench for image_logic_engine at 4x4: vector table plus stall, reset-abort and back-to-back sequences.
module tb_image_logic_engine;
  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0, out_ready = 0;
  logic        use_acc = 0, clear_acc = 0, store_acc = 0;
  logic [15:0] imgA = 0, imgB = 0;
  logic [2:0]  op = 0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [4:0]  ones;

  int errors = 0, checks = 0, cyc = 0;

  image_logic_engine #(.ImageWidth(4), .ImageHeight(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imgA(imgA), .imgB(imgB), .op(op), .use_acc(use_acc), .clear_acc(clear_acc),
    .store_acc(store_acc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ones(ones), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a, b;
    logic [2:0]  op;
    logic        u, c, s;
    logic [15:0] er;
    logic [4:0]  eo;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_ones"}, 32'(ones), 0);
  endtask

  // Returns #1 after the edge following acceptance (cycle T+1).
  task automatic accept_req(input logic [15:0] a, b, input logic [2:0] o,
                            input logic u, c, s, output bit ok);
    ok = 0;
    imgA = a; imgB = b; op = o; use_acc = u; clear_acc = c; store_acc = s;
    in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    imgA = ~a; imgB = ~b; op = ~o; use_acc = ~u; clear_acc = 0; store_acc = ~s;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit ok;
    int lat;
    accept_req(v.a, v.b, v.op, v.u, v.c, v.s, ok);
    if (!ok) return;
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 6);
    chk({tag, "_result"}, 32'(result), 32'(v.er));
    chk({tag, "_ones"}, 32'(ones), 32'(v.eo));
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    bit ok;
    int lat, n;
    int stamp[3];

    vecs[0]  = '{16'h1234, 16'h00FF, 3'b000, 0, 0, 0, 16'h1234, 5'd5};
    vecs[1]  = '{16'h1234, 16'h00FF, 3'b001, 0, 0, 0, 16'h00FF, 5'd8};
    vecs[2]  = '{16'h1234, 16'h00FF, 3'b010, 0, 0, 0, 16'hEDCB, 5'd11};
    vecs[3]  = '{16'h1234, 16'h00FF, 3'b011, 0, 0, 0, 16'hFF00, 5'd8};
    vecs[4]  = '{16'h1234, 16'h00FF, 3'b100, 0, 0, 0, 16'h0034, 5'd3};
    vecs[5]  = '{16'h1234, 16'h00FF, 3'b101, 0, 0, 0, 16'h12FF, 5'd10};
    vecs[6]  = '{16'h1234, 16'h00FF, 3'b110, 0, 0, 0, 16'h12CB, 5'd7};
    vecs[7]  = '{16'h1234, 16'h00FF, 3'b111, 0, 0, 0, 16'hED34, 5'd9};
    vecs[8]  = '{16'hF0F0, 16'hFF00, 3'b100, 0, 0, 0, 16'hF000, 5'd4};
    vecs[9]  = '{16'h9999, 16'h1111, 3'b000, 1, 1, 1, 16'h0000, 5'd0};
    vecs[10] = '{16'h5A5A, 16'h0000, 3'b010, 1, 0, 0, 16'hFFFF, 5'd16};
    vecs[11] = '{16'h0F0F, 16'h00F0, 3'b101, 0, 0, 1, 16'h0FFF, 5'd12};
    vecs[12] = '{16'h3333, 16'h0FF0, 3'b110, 1, 0, 0, 16'h000F, 5'd4};

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    idle_chk("in_reset");
    reset = 0;
    idle_chk("post_reset");

    for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stall in DONE while a competing request toggles
    accept_req(16'hAAAA, 16'h0F0F, 3'b110, 0, 0, 0, ok);
    wait_done(lat);
    chk("stall_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      imgA = 16'($urandom);
      op = 3'b000;
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_result", 32'(result), 32'hA5A5);
      chk("stall_ones", 32'(ones), 8);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("post_stall_in_ready", 32'(in_ready), 1);
    chk("post_stall_out_valid", 32'(out_valid), 0);
    chk("post_stall_result_hold", 32'(result), 32'hA5A5);
    chk("post_stall_ones_hold", 32'(ones), 8);

    // Reset in the second COUNT cycle of a storing transaction
    accept_req(16'h1111, 16'hABCD, 3'b001, 0, 0, 1, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 1);
    reset = 1;
    #1;
    idle_chk("abort_in_reset");
    @(posedge clk); #1;
    reset = 0;
    idle_chk("abort_after");
    run_txn('{16'h5555, 16'h0000, 3'b000, 1, 0, 0, 16'h0000, 5'd0}, "acc_after_abort");

    // Back-to-back with both handshakes held high
    imgA = 16'h00FF; imgB = 16'h0F0F; op = 3'b100;
    use_acc = 0; clear_acc = 0; store_acc = 0;
    in_valid = 1; out_ready = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      if (in_ready) begin
        stamp[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("b2b_accepts", 32'(n), 3);
    if (n == 3) begin
      chk("b2b_gap0", 32'(stamp[1] - stamp[0]), 7);
      chk("b2b_gap1", 32'(stamp[2] - stamp[1]), 7);
    end
    repeat (10) @(posedge clk);
    #1;
    out_ready = 0;
    chk("b2b_result", 32'(result), 32'h000F);
    chk("b2b_ones", 32'(ones), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_logic_engine.md
IMAGE_LOGIC_ENGINE -- requirements
Module: image_logic_engine

Interface
REQ-001 The block SHALL have parameter ImageWidth, default 8, meaning pixels per row (bits per row slice).
REQ-002 The block SHALL have parameter ImageHeight, default 8, meaning rows per image.
REQ-003 The block SHALL use local width N = ImageWidth*ImageHeight and local width CW = clog2(N+1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the request fields are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-008 The block SHALL have ports imgA and imgB, input, N bits each, the operand images; pixel (r,c) is bit r*ImageWidth+c.
REQ-009 The block SHALL have port op, input, 3 bits, the operation code (see REQ-016).
REQ-010 The block SHALL have port use_acc, input, 1 bit, meaning operand A is the accumulator instead of imgA.
REQ-011 The block SHALL have port clear_acc, input, 1 bit, meaning operand A is all-zero; it takes priority over use_acc.
REQ-012 The block SHALL have port store_acc, input, 1 bit, meaning the result is written to the accumulator.
REQ-013 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the result handshake.
REQ-014 The block SHALL have ports result (output, N bits), the operation result, and ones (output, CW bits), the count of set pixels in result.
REQ-015 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-016 The op encoding SHALL be: 000 A; 001 B; 010 ~A; 011 ~B; 100 A&B; 101 A|B; 110 A^B; 111 ~(A^B).
REQ-017 The FSM SHALL have states IDLE, CALC, COUNT and DONE.
REQ-018 in_ready SHALL equal 1 only in IDLE; a request is accepted when in_valid and in_ready are both high.
REQ-019 On acceptance the block SHALL latch operand A (0 if clear_acc, else acc if use_acc, else imgA), imgB, op and store_acc, and go to CALC.
REQ-020 In CALC the block SHALL register result = op(A,B), clear ones and the row index to 0, write acc <= result if store_acc was latched, and go to COUNT.
REQ-021 COUNT SHALL last exactly ImageHeight cycles; in each cycle ones += popcount(result row[idx]) and idx increments; after row ImageHeight-1 the FSM goes to DONE.
REQ-022 out_valid SHALL equal 1 only in DONE; result and ones SHALL be stable while out_valid is high.
REQ-023 In DONE, out_ready high SHALL return the FSM to IDLE; there is no bypass, so a new request is accepted no earlier than the cycle after the handshake.
REQ-024 If a request is accepted in cycle T, out_valid SHALL first be high in cycle T+2+ImageHeight.
REQ-025 in_valid and request fields outside IDLE SHALL be ignored; imgA/imgB changes after acceptance SHALL not affect the result.
REQ-026 result SHALL hold its value until the next CALC; ones SHALL hold its value until the next CALC clears it.
REQ-027 ones SHALL never overflow; its maximum value is N, for an all-ones result.
REQ-028 Chained use SHALL be supported: a request with use_acc=1 issued after a store_acc transaction sees the stored result.

Reset
REQ-029 While reset is high, the FSM SHALL go to IDLE and acc, result, ones and the row index SHALL be cleared to 0.
REQ-030 Outputs during reset and in the first cycle after it SHALL be: in_ready=1, out_valid=0, busy=0, result=0, ones=0.
REQ-031 A reset asserted in CALC, COUNT or DONE SHALL abort the transaction with no output handshake, and the accumulator SHALL read 0 afterwards.

Verification (ImageWidth=ImageHeight=4, N=16)
REQ-032 Scenario: imgA=0xF0F0, imgB=0xFF00, op=100, accepted in cycle T -> out_valid first high in cycle T+6, result=0xF000, ones=4.
REQ-033 Scenario: all 8 ops with A=0x1234, B=0x00FF -> results 1234, 00FF, EDCB, FF00, 0034, 12FF, 12CB, ED34, each with the matching popcount.
REQ-034 Scenario: op=000, clear_acc=1, store_acc=1, then op=010, use_acc=1 -> first result 0x0000 with ones=0, second result 0xFFFF with ones=16.
REQ-035 Scenario: hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> out_valid, result and ones stay stable, in_ready stays 0, and the extra request is not accepted.
REQ-036 Scenario: reset asserted in the 2nd COUNT cycle after a store_acc request -> next cycle shows IDLE values (REQ-030), and a following use_acc, op=000 request returns 0x0000.
REQ-037 Scenario: back-to-back requests with in_valid and out_ready held high -> each transaction takes ImageHeight+3 cycles from acceptance to the next acceptance.
